// File: rtl/psr_ddc_pkg.sv
// Shared constants and types for the DDC power/gain chain: data widths,
// saturation ceiling, bin-index width helper and the arming state encoding.
package psr_ddc_pkg;

   localparam int DATA_W = 16;
   localparam int PARA_W = 32;
   localparam logic [PARA_W-1:0] PARA_MAX = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_UNARMED = 1'b0,
      ST_ARMED   = 1'b1
   } arm_state_e;

   function automatic int idx_width(input int bitwidth);
      return bitwidth + 2;
   endfunction

endpackage

// File: rtl/cplx_power_sq.sv
// Two-stage |x|^2 of a signed complex sample: stage 1 registers the operands,
// stage 2 registers the squares; the output is their unsigned 32-bit sum.
module cplx_power_sq
   import psr_ddc_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] re_i,
   input  logic [DATA_W-1:0] im_i,
   output logic [PARA_W-1:0] pwr_o
);

   logic signed [DATA_W-1:0] re_q;
   logic signed [DATA_W-1:0] im_q;
   logic        [PARA_W-1:0] re_sq_s;
   logic        [PARA_W-1:0] im_sq_s;
   logic        [PARA_W-1:0] re_sq_q;
   logic        [PARA_W-1:0] im_sq_q;

   // Each square is at most 2^30, so the sum never reaches bit 32.
   assign re_sq_s = re_q * re_q;
   assign im_sq_s = im_q * im_q;
   assign pwr_o   = re_sq_q + im_sq_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         re_q    <= '0;
         im_q    <= '0;
         re_sq_q <= '0;
         im_sq_q <= '0;
      end else begin
         re_q    <= re_i;
         im_q    <= im_i;
         re_sq_q <= re_sq_s;
         im_sq_q <= im_sq_s;
      end
   end

endmodule

// File: rtl/spectrum_power_acc.sv
// Per-bin |X|^2 accumulated over acc_len+1 spectra, dumped as a 32-bit stream
// with 3-cycle fixed latency. Define ACC_SATURATE_EN to clamp sums and drive ovf.
module spectrum_power_acc
   import psr_ddc_pkg::*;
#(
   parameter int BITWIDTH  = 7,
   parameter int FFT_POINT = 512,
   parameter int ACC_LEN_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_sync_in,
   input  logic [BITWIDTH+1:0]  cnt_sync_in,
   input  logic [DATA_W-1:0]    re_in,
   input  logic [DATA_W-1:0]    im_in,
   input  logic [ACC_LEN_W-1:0] acc_len,
   output logic [PARA_W-1:0]    para_out0,
   output logic                 en_sync_out,
   output logic [BITWIDTH+1:0]  cnt_sync_out,
   output logic                 ms_out,
   output logic                 ovf
);

   localparam int IW = idx_width(BITWIDTH);
   localparam logic [IW-1:0]        LAST_IDX = IW'(FFT_POINT - 1);
   localparam logic [IW-1:0]        IDX_ONE  = IW'(1);
   localparam logic [ACC_LEN_W-1:0] SPEC_ONE = ACC_LEN_W'(1);

   arm_state_e            state_q, state_d;
   logic [IW-1:0]         prev_q, prev_d;
   logic [ACC_LEN_W-1:0]  spec_q, spec_d;
   logic [ACC_LEN_W-1:0]  len_q, len_d;
   logic                  take_s, restart_s;
   logic [ACC_LEN_W-1:0]  cur_spec_s, cur_len_s;

   logic                  v1_q, first1_q, last1_q, ms1_q;
   logic [IW-1:0]         idx1_q;
   logic                  v2_q, first2_q, last2_q, ms2_q;
   logic [IW-1:0]         idx2_q;

   logic [PARA_W-1:0]     mem_q [0:FFT_POINT-1];
   logic [PARA_W-1:0]     rd_q;
   logic [PARA_W-1:0]     pwr_s, base_s, sum_s;
   logic                  sat_s;

   logic [PARA_W-1:0]     para_q, para_d;
   logic                  en_q, en_d, ms_q, ms_d, ovf_q, ovf_d;
   logic [IW-1:0]         cnt_q, cnt_d;

   cplx_power_sq u_pwr (
      .clk_i (clk),
      .rst_i (rst),
      .re_i  (re_in),
      .im_i  (im_in),
      .pwr_o (pwr_s)
   );

   // Arming, index continuity, spectrum counting and length sampling per beat.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      spec_d     = spec_q;
      len_d      = len_q;
      take_s     = 1'b0;
      restart_s  = 1'b0;
      cur_spec_s = spec_q;
      cur_len_s  = len_q;
      if (en_sync_in) begin
         case (state_q)
            ST_UNARMED: begin
               take_s    = (cnt_sync_in == '0);
               restart_s = (cnt_sync_in == '0);
            end
            ST_ARMED: begin
               if (cnt_sync_in == '0) begin
                  take_s    = 1'b1;
                  restart_s = (prev_q != LAST_IDX);
               end else begin
                  take_s    = (cnt_sync_in == prev_q + IDX_ONE);
                  restart_s = 1'b0;
               end
            end
            default: begin
               take_s    = 1'b0;
               restart_s = 1'b0;
            end
         endcase
         if (restart_s) cur_spec_s = '0;
         else           cur_spec_s = spec_q;
         if (take_s && (cnt_sync_in == '0) && (cur_spec_s == '0)) cur_len_s = acc_len;
         else                                                     cur_len_s = len_q;
         if (take_s) begin
            state_d = ST_ARMED;
            prev_d  = cnt_sync_in;
            len_d   = cur_len_s;
            if (cnt_sync_in == LAST_IDX) begin
               if (cur_spec_s == cur_len_s) spec_d = '0;
               else                         spec_d = cur_spec_s + SPEC_ONE;
            end else begin
               spec_d = cur_spec_s;
            end
         end else begin
            state_d = ST_UNARMED;
            spec_d  = '0;
         end
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_UNARMED;
         prev_q  <= '0;
         spec_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         spec_q  <= spec_d;
         len_q   <= len_d;
      end
   end

   // Read is issued from stage 1; the first spectrum ignores stale memory.
   always_ff @(posedge clk) begin
      rd_q <= mem_q[idx1_q];
      if (v2_q) mem_q[idx2_q] <= sum_s;
   end

   assign base_s = first2_q ? '0 : rd_q;

`ifdef ACC_SATURATE_EN
   logic [PARA_W:0] sum_wide_s;
   assign sum_wide_s = {1'b0, base_s} + {1'b0, pwr_s};
   assign sat_s      = sum_wide_s[PARA_W];
   assign sum_s      = sat_s ? PARA_MAX : sum_wide_s[PARA_W-1:0];
`else
   assign sat_s = 1'b0;
   assign sum_s = base_s + pwr_s;
`endif

   // Output stage: data only on dump beats; ovf restarts with each dump's bin 0.
   always_comb begin
      en_d   = v2_q & last2_q;
      ms_d   = v2_q & ms2_q;
      para_d = '0;
      cnt_d  = '0;
      ovf_d  = ovf_q;
      if (en_d) begin
         para_d = sum_s;
         cnt_d  = idx2_q;
      end else begin
         para_d = '0;
         cnt_d  = '0;
      end
      if (ms_d)      ovf_d = sat_s;
      else if (v2_q) ovf_d = ovf_q | sat_s;
      else           ovf_d = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         idx1_q   <= '0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         ms1_q    <= 1'b0;
         v2_q     <= 1'b0;
         idx2_q   <= '0;
         first2_q <= 1'b0;
         last2_q  <= 1'b0;
         ms2_q    <= 1'b0;
         para_q   <= '0;
         en_q     <= 1'b0;
         cnt_q    <= '0;
         ms_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         v1_q     <= take_s;
         idx1_q   <= cnt_sync_in;
         first1_q <= (cur_spec_s == '0);
         last1_q  <= (cur_spec_s == cur_len_s);
         ms1_q    <= (cur_spec_s == cur_len_s) && (cnt_sync_in == '0);
         v2_q     <= v1_q;
         idx2_q   <= idx1_q;
         first2_q <= first1_q;
         last2_q  <= last1_q;
         ms2_q    <= ms1_q;
         para_q   <= para_d;
         en_q     <= en_d;
         cnt_q    <= cnt_d;
         ms_q     <= ms_d;
         ovf_q    <= ovf_d;
      end
   end

   assign para_out0    = para_q;
   assign en_sync_out  = en_q;
   assign cnt_sync_out = cnt_q;
   assign ms_out       = ms_q;
   assign ovf          = ovf_q;

endmodule

// File: tb/tb_spectrum_power_acc.sv
// Randomized bench for spectrum_power_acc with a per-beat behavioural model
// of the accumulate/dump rules; expected outputs are compared 3 cycles later.
module tb_spectrum_power_acc;

   localparam int BW   = 4;
   localparam int FFT  = 64;
   localparam int IW   = BW + 2;
   localparam int ALW  = 8;
   localparam int MAXE = 32768;

   typedef struct {
      bit          en;
      int          idx;
      logic [31:0] data;
      bit          ms;
      bit          ovf;
      int          phase;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            en_sync_in;
   logic [IW-1:0]   cnt_sync_in;
   logic [15:0]     re_in, im_in;
   logic [ALW-1:0]  acc_len;
   logic [31:0]     para_out0;
   logic            en_sync_out;
   logic [IW-1:0]   cnt_sync_out;
   logic            ms_out;
   logic            ovf;

   spectrum_power_acc #(.BITWIDTH(BW), .FFT_POINT(FFT), .ACC_LEN_W(ALW)) dut (
      .clk          (clk),
      .rst          (rst),
      .en_sync_in   (en_sync_in),
      .cnt_sync_in  (cnt_sync_in),
      .re_in        (re_in),
      .im_in        (im_in),
      .acc_len      (acc_len),
      .para_out0    (para_out0),
      .en_sync_out  (en_sync_out),
      .cnt_sync_out (cnt_sync_out),
      .ms_out       (ms_out),
      .ovf          (ovf)
   );

   always #5 clk = ~clk;

   int     edge_cnt = 0;
   int     n_pass = 0;
   int     n_tot = 0;
   bit     chk_on = 1'b0;
   int     cur_phase = 0;
   int     cur_alen = 0;
   exp_t   exp_a [MAXE];
   exp_t   ce;

   // reference model state
   bit     m_armed = 1'b0;
   int     m_prev = 0;
   int     m_spec = 0;
   int     m_len = 0;
   bit     m_ovf = 1'b0;
   longint m_acc [FFT];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
   endtask

   function automatic exp_t idle_e(input bit ov, input int ph);
      exp_t e;
      e.en = 1'b0; e.idx = 0; e.data = 32'h0; e.ms = 1'b0; e.ovf = ov; e.phase = ph;
      return e;
   endfunction

   // Spectrum rules: bin 0 arms, index must step by 1, spec 0 overwrites, last spectrum dumps.
   task automatic model_beat(input bit v, input int idx, input int re, input int im, input int b);
      exp_t   e;
      bit     take;
      bit     sat;
      longint p, s;
      e = idle_e(1'b0, cur_phase);
      take = 1'b0;
      sat = 1'b0;
      if (v) begin
         if (idx == 0) begin
            take = 1'b1;
            if (!(m_armed && m_prev == FFT - 1)) m_spec = 0;
            if (m_spec == 0) m_len = cur_alen;
         end else if (m_armed && idx == m_prev + 1) begin
            take = 1'b1;
         end
         if (take) begin
            p = longint'(re) * re + longint'(im) * im;
            s = ((m_spec == 0) ? 64'sd0 : m_acc[idx]) + p;
`ifdef ACC_SATURATE_EN
            if (s > 64'sh0_FFFF_FFFF) begin s = 64'sh0_FFFF_FFFF; sat = 1'b1; end
`else
            s = s & 64'sh0_FFFF_FFFF;
`endif
            m_acc[idx] = s;
            if (m_spec == m_len) begin
               e.en = 1'b1; e.idx = idx; e.data = s[31:0]; e.ms = (idx == 0);
               if (idx == 0) m_ovf = sat;
               else          m_ovf = m_ovf | sat;
            end else begin
               m_ovf = m_ovf | sat;
            end
            m_armed = 1'b1;
            m_prev = idx;
            if (idx == FFT - 1) m_spec = (m_spec == m_len) ? 0 : m_spec + 1;
         end else begin
            m_armed = 1'b0;
         end
      end
      e.ovf = m_ovf;
      exp_a[b] = e;
   endtask

   task automatic beat(input bit v, input int idx, input int re, input int im);
      @(posedge clk); #1;
      rst = 1'b0;
      en_sync_in = v;
      cnt_sync_in = idx[IW-1:0];
      re_in = re[15:0];
      im_in = im[15:0];
      acc_len = cur_alen[ALW-1:0];
      model_beat(v, idx, re, im, edge_cnt + 1);
   endtask

   task automatic idle_beat();
      beat(1'b0, $urandom_range(0, FFT - 1), 0, 0);
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic rnd_spectrum(input int first, input int last, input bit bubbles);
      for (int k = first; k <= last; k++) begin
         if (bubbles) while ($urandom_range(0, 1) == 0) idle_beat();
         beat(1'b1, k, rnd16(), rnd16());
      end
   endtask

   // One-cycle reset: in-flight beats vanish and outputs clear right after the edge.
   task automatic do_rst();
      int b;
      @(posedge clk); #1;
      rst = 1'b1;
      en_sync_in = 1'b0;
      b = edge_cnt + 1;
      m_armed = 1'b0; m_spec = 0; m_len = 0; m_prev = 0; m_ovf = 1'b0;
      exp_a[b-2] = idle_e(1'b0, cur_phase);
      exp_a[b-1] = idle_e(1'b0, cur_phase);
      exp_a[b]   = idle_e(1'b0, cur_phase);
      @(posedge clk); #1;
      chk("rst_para_out0", para_out0, 32'h0);
      chk("rst_en_sync_out", en_sync_out, 32'h0);
      chk("rst_cnt_sync_out", cnt_sync_out, 32'h0);
      chk("rst_ms_out", ms_out, 32'h0);
      chk("rst_ovf", ovf, 32'h0);
      rst = 1'b0;
      exp_a[b+1] = idle_e(1'b0, cur_phase);
   endtask

   // Compare process: outputs after edge e belong to the beat captured at edge e-2.
   always @(negedge clk) begin
      if (chk_on && edge_cnt >= 2) begin
         ce = exp_a[edge_cnt-2];
         chk("en_sync_out", en_sync_out, 32'(ce.en));
         chk("ms_out", ms_out, 32'(ce.ms));
         chk("ovf", ovf, 32'(ce.ovf));
         if (ce.en) begin
            chk("cnt_sync_out", cnt_sync_out, 32'(ce.idx));
            chk("para_out0", para_out0, ce.data);
            case (ce.phase)
               1: chk("lit_no_acc_25", para_out0, 32'd25);
               2: chk("lit_four_spec_4k2", para_out0, 32'(4 * ce.idx * ce.idx));
               3: begin
`ifdef ACC_SATURATE_EN
                  chk("lit_sat_value", para_out0, 32'hFFFF_FFFF);
                  chk("lit_sat_ovf", ovf, 32'h1);
`else
                  chk("lit_wrap_value", para_out0, 32'h0);
                  chk("lit_wrap_ovf", ovf, 32'h0);
`endif
               end
               default: ;
            endcase
         end
      end
   end

   initial begin
      for (int i = 0; i < MAXE; i++) exp_a[i] = idle_e(1'b0, 0);
      for (int i = 0; i < FFT; i++) m_acc[i] = 0;
      rst = 1'b1;
      en_sync_in = 1'b0;
      cnt_sync_in = '0;
      re_in = '0;
      im_in = '0;
      acc_len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_para_out0", para_out0, 32'h0);
      chk("init_en_sync_out", en_sync_out, 32'h0);
      chk("init_cnt_sync_out", cnt_sync_out, 32'h0);
      chk("init_ms_out", ms_out, 32'h0);
      chk("init_ovf", ovf, 32'h0);
      rst = 1'b0;
      chk_on = 1'b1;

      // no accumulation, constant 3+4j
      cur_phase = 1; cur_alen = 0;
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < FFT; k++) beat(1'b1, k, 3, 4);

      // four-spectrum accumulation of re=k
      cur_phase = 2; cur_alen = 3;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < FFT; k++) beat(1'b1, k, k, 0);

      // 256 spectra of full-scale input
      cur_phase = 3; cur_alen = 255;
      for (int s = 0; s < 256; s++)
         for (int k = 0; k < FFT; k++) beat(1'b1, k, -32768, -32768);

      // arming mid-spectrum after reset
      cur_phase = 0;
      do_rst();
      cur_alen = 1;
      rnd_spectrum(20, FFT - 1, 1'b0);
      for (int s = 0; s < 2; s++) rnd_spectrum(0, FFT - 1, 1'b0);

      // random bubbles
      cur_alen = 2;
      for (int s = 0; s < 6; s++) rnd_spectrum(0, FFT - 1, 1'b1);

      // reset in the middle of a dump, then a clean stream
      cur_alen = 1;
      rnd_spectrum(0, FFT - 1, 1'b0);
      rnd_spectrum(0, 30, 1'b0);
      do_rst();
      for (int s = 0; s < 2; s++) rnd_spectrum(0, FFT - 1, 1'b0);

      // skipped index drops the dump; early bin 0 re-arms at once
      rnd_spectrum(0, 10, 1'b0);
      rnd_spectrum(12, FFT - 1, 1'b0);
      for (int s = 0; s < 2; s++) rnd_spectrum(0, FFT - 1, 1'b0);
      rnd_spectrum(0, 40, 1'b0);
      for (int s = 0; s < 2; s++) rnd_spectrum(0, FFT - 1, 1'b1);

      repeat (6) idle_beat();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
